// File: rtl/irq_arbiter.sv
// External interrupt arbiter: synchronises device lines, latches edge/level requests and
// presents the highest-priority eligible source as one cause bit with in-service nesting.
module irq_arbiter #(
  parameter int unsigned N_SRC   = 8,
  parameter int unsigned CA_BASE = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] irq,
  input  logic             jisr,
  input  logic             eoi,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_addr,
  input  logic [31:0]      cfg_wdata,
  output logic [31:0]      cfg_rdata,
  output logic [22:0]      ca_ext,
  output logic             irq_valid,
  output logic [3:0]       irq_id
);

  typedef enum logic [1:0] {StIdle, StReq, StAck} state_e;

  state_e           state_q, state_d;
  logic [N_SRC-1:0] s1_q, s2_q, prev_q;
  logic [N_SRC-1:0] enable_q, enable_d, edge_q, edge_d;
  logic [N_SRC-1:0] pending_q, pending_d, insvc_q, insvc_d;
  logic [3:0]       irq_id_q, irq_id_d;
  logic [22:0]      ca_ext_q, ca_ext_d;

  logic [N_SRC-1:0] wdata, insvc_low, elig_mask, eligible, win_oh, ack_oh, edge_set, pend_clr;
  logic [3:0]       win_id;
  logic             any_elig;
  logic             unused_wdata;

  assign wdata        = cfg_wdata[N_SRC-1:0];
  assign unused_wdata = ^cfg_wdata;

  // Only sources strictly above the highest-priority in-service one may nest;
  // with nothing in service, insvc_low is zero and the mask wraps to all ones.
  assign insvc_low = insvc_q & (~insvc_q + N_SRC'(1));
  assign elig_mask = insvc_low - N_SRC'(1);
  assign eligible  = pending_q & enable_q & elig_mask;
  assign win_oh    = eligible & (~eligible + N_SRC'(1));
  assign any_elig  = |eligible;
  assign edge_set  = s2_q & ~prev_q & edge_q;

  always_comb begin
    win_id = '0;
    ack_oh = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) win_id = 4'(i);
    end
    for (int i = 0; i < N_SRC; i++) begin
      if (irq_id_q == 4'(i)) ack_oh[i] = 1'b1;
    end
  end

  always_comb begin
    enable_d = enable_q;
    edge_d   = edge_q;
    pend_clr = '0;
    insvc_d  = insvc_q;
    if (cfg_we && cfg_addr == 2'd0) enable_d = wdata;
    if (cfg_we && cfg_addr == 2'd1) edge_d = wdata;
    if (cfg_we && cfg_addr == 2'd2) pend_clr = wdata;
    if (state_q == StAck) pend_clr = pend_clr | (ack_oh & edge_q);
    // A new edge wins over any clear in the same cycle.
    pending_d = (edge_q & (edge_set | (pending_q & ~pend_clr))) | (~edge_q & s2_q);
    if (eoi) insvc_d = insvc_d & ~insvc_low;
    if (cfg_we && cfg_addr == 2'd3) insvc_d = insvc_d & ~wdata;
    if (state_q == StAck) insvc_d = insvc_d | ack_oh;
  end

  always_comb begin
    state_d  = state_q;
    irq_id_d = irq_id_q;
    ca_ext_d = '0;
    unique case (state_q)
      StIdle: begin
        if (any_elig) begin
          state_d  = StReq;
          irq_id_d = win_id;
          ca_ext_d = 23'(win_oh) << CA_BASE;
        end
      end
      StReq: begin
        if (jisr) begin
          state_d = StAck;
        end else if (any_elig) begin
          irq_id_d = win_id;
          ca_ext_d = 23'(win_oh) << CA_BASE;
        end else begin
          state_d = StIdle;
        end
      end
      StAck:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StIdle;
      s1_q      <= '0;
      s2_q      <= '0;
      prev_q    <= '0;
      enable_q  <= '0;
      edge_q    <= '0;
      pending_q <= '0;
      insvc_q   <= '0;
      irq_id_q  <= '0;
      ca_ext_q  <= '0;
    end else begin
      state_q   <= state_d;
      s1_q      <= irq;
      s2_q      <= s1_q;
      prev_q    <= s2_q;
      enable_q  <= enable_d;
      edge_q    <= edge_d;
      pending_q <= pending_d;
      insvc_q   <= insvc_d;
      irq_id_q  <= irq_id_d;
      ca_ext_q  <= ca_ext_d;
    end
  end

  assign ca_ext    = ca_ext_q;
  assign irq_valid = (state_q == StReq);
  assign irq_id    = irq_id_q;

  always_comb begin
    unique case (cfg_addr)
      2'd0:    cfg_rdata = 32'(enable_q);
      2'd1:    cfg_rdata = 32'(edge_q);
      2'd2:    cfg_rdata = 32'(pending_q);
      default: cfg_rdata = 32'(insvc_q);
    endcase
  end

endmodule

// File: tb/tb_irq_arbiter.sv
// Bench for irq_arbiter: cycle-level behavioural model checked every cycle, plus directed
// scenarios with hand-computed expectations.
module tb_irq_arbiter;

  localparam int N  = 8;
  localparam int CB = 7;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] irq = '0;
  logic         jisr = 1'b0;
  logic         eoi = 1'b0;
  logic         cfg_we = 1'b0;
  logic [1:0]   cfg_addr = 2'd0;
  logic [31:0]  cfg_wdata = '0;
  logic [31:0]  cfg_rdata;
  logic [22:0]  ca_ext;
  logic         irq_valid;
  logic [3:0]   irq_id;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  // Model state: m_state 0 = idle, 1 = presenting a request, 2 = acknowledge cycle.
  logic [N-1:0] m_s1 = '0, m_s2 = '0, m_prev = '0;
  logic [N-1:0] m_en = '0, m_edge = '0, m_pend = '0, m_insvc = '0;
  int           m_state = 0;
  int           m_id = 0;

  irq_arbiter #(.N_SRC(N), .CA_BASE(CB)) dut (
    .clk       (clk),
    .rst       (rst),
    .irq       (irq),
    .jisr      (jisr),
    .eoi       (eoi),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .cfg_rdata (cfg_rdata),
    .ca_ext    (ca_ext),
    .irq_valid (irq_valid),
    .irq_id    (irq_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lowest(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return N;
  endfunction

  task automatic model_step();
    logic [N-1:0] elig, n_pend, n_insvc, n_en, n_edge;
    int lo, win;
    bit set, clr;
    if (!rst) begin
      m_s1 = '0; m_s2 = '0; m_prev = '0;
      m_en = '0; m_edge = '0; m_pend = '0; m_insvc = '0;
      m_state = 0; m_id = 0;
      return;
    end
    lo = lowest(m_insvc);
    for (int i = 0; i < N; i++) elig[i] = m_pend[i] && m_en[i] && (i < lo);
    win = lowest(elig);
    for (int i = 0; i < N; i++) begin
      if (m_edge[i]) begin
        set = m_s2[i] && !m_prev[i];
        clr = (cfg_we && cfg_addr == 2'd2 && cfg_wdata[i]) || (m_state == 2 && m_id == i);
        n_pend[i] = set || (m_pend[i] && !clr);
      end else begin
        n_pend[i] = m_s2[i];
      end
    end
    n_insvc = m_insvc;
    if (eoi && lo < N) n_insvc[lo] = 1'b0;
    if (cfg_we && cfg_addr == 2'd3) n_insvc = n_insvc & ~cfg_wdata[N-1:0];
    if (m_state == 2) n_insvc[m_id] = 1'b1;
    n_en   = (cfg_we && cfg_addr == 2'd0) ? cfg_wdata[N-1:0] : m_en;
    n_edge = (cfg_we && cfg_addr == 2'd1) ? cfg_wdata[N-1:0] : m_edge;
    case (m_state)
      0: if (win < N) begin m_state = 1; m_id = win; end
      1: begin
        if (jisr) m_state = 2;
        else if (win < N) m_id = win;
        else m_state = 0;
      end
      default: m_state = 0;
    endcase
    m_pend = n_pend; m_insvc = n_insvc; m_en = n_en; m_edge = n_edge;
    m_prev = m_s2; m_s2 = m_s1; m_s1 = irq;
  endtask

  function automatic logic [31:0] model_rdata(input logic [1:0] a);
    case (a)
      2'd0:    return 32'(m_en);
      2'd1:    return 32'(m_edge);
      2'd2:    return 32'(m_pend);
      default: return 32'(m_insvc);
    endcase
  endfunction

  always @(posedge clk) begin
    model_step();
    #1;
    if (check_en) begin
      chk("cyc_irq_valid", 32'(irq_valid), 32'(m_state == 1));
      chk("cyc_irq_id", 32'(irq_id), 32'(m_id));
      chk("cyc_ca_ext", 32'(ca_ext), (m_state == 1) ? (32'd1 << (CB + m_id)) : 32'd0);
      chk("cyc_cfg_rdata", cfg_rdata, model_rdata(cfg_addr));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_pos(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    @(negedge clk);
    cfg_we = 1'b0; cfg_wdata = '0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string name);
    cfg_addr = a;
    #1;
    chk(name, cfg_rdata, exp);
  endtask

  task automatic ack();
    @(negedge clk); jisr = 1'b1;
    @(negedge clk); jisr = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse(input int b);
    irq[b] = 1'b1;
    tick(2);
    irq[b] = 1'b0;
  endtask

  task automatic lit_out(input string name, input logic v, input logic [3:0] id,
                         input logic [22:0] ca);
    chk({name, "_valid"}, 32'(irq_valid), 32'(v));
    chk({name, "_id"}, 32'(irq_id), 32'(id));
    chk({name, "_ca"}, 32'(ca_ext), 32'(ca));
  endtask

  initial begin
    tick(2);
    rst = 1'b1;
    check_en = 1'b1;

    // Single edge source 0: latency and acknowledge.
    cfg_write(2'd0, 32'h01);
    cfg_write(2'd1, 32'h01);
    irq[0] = 1'b1;
    wait_pos(3);
    chk("t1_not_yet", 32'(irq_valid), 32'd0);
    wait_pos(1);
    lit_out("t1_req", 1'b1, 4'd0, 23'h80);
    @(negedge clk); jisr = 1'b1;
    wait_pos(1);
    lit_out("t1_ack", 1'b0, 4'd0, 23'h0);
    @(negedge clk); jisr = 1'b0;
    wait_pos(1);
    @(negedge clk);
    rd(2'd3, 32'h01, "t1_insvc");
    rd(2'd2, 32'h00, "t1_pending");
    irq[0] = 1'b0;
    @(negedge clk); eoi = 1'b1;
    @(negedge clk); eoi = 1'b0;

    // Higher-priority arrival replaces the presented source.
    cfg_write(2'd0, 32'hFF);
    cfg_write(2'd1, 32'hFF);
    irq[5] = 1'b1;
    @(negedge clk); irq[2] = 1'b1;
    wait_pos(3);
    lit_out("t2_id5", 1'b1, 4'd5, 23'h1000);
    wait_pos(1);
    lit_out("t2_id2", 1'b1, 4'd2, 23'h200);
    irq = '0;
    ack();
    rd(2'd3, 32'h04, "t2_insvc");
    rd(2'd2, 32'h20, "t2_pending");

    // Lower-priority source blocked by source 2 in service until eoi.
    cfg_write(2'd2, 32'h20);
    pulse(3);
    tick(4);
    chk("t3_blocked", 32'(irq_valid), 32'd0);
    rd(2'd2, 32'h08, "t3_pending");
    eoi = 1'b1;
    @(negedge clk); eoi = 1'b0;
    wait_pos(1);
    lit_out("t3_req", 1'b1, 4'd3, 23'h400);
    ack();

    // Level source dropped before acknowledge.
    cfg_write(2'd3, 32'hFF);
    cfg_write(2'd1, 32'h00);
    irq[1] = 1'b1;
    wait_pos(4);
    lit_out("t4_req", 1'b1, 4'd1, 23'h100);
    @(negedge clk); irq[1] = 1'b0;
    wait_pos(4);
    lit_out("t4_drop", 1'b0, 4'd1, 23'h0);
    rd(2'd3, 32'h00, "t4_insvc");

    // Reset in the middle of a request.
    cfg_write(2'd1, 32'h10);
    irq[4] = 1'b1;
    tick(2);
    irq[4] = 1'b0;
    wait_pos(2);
    lit_out("t5_req", 1'b1, 4'd4, 23'h800);
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    #1;
    lit_out("t5_rst", 1'b0, 4'd0, 23'h0);
    rd(2'd0, 32'h00, "t5_enable");
    rd(2'd1, 32'h00, "t5_edge");
    rd(2'd2, 32'h00, "t5_pending");
    rd(2'd3, 32'h00, "t5_insvc");
    pulse(4);
    tick(5);
    chk("t5_quiet", 32'(irq_valid), 32'd0);

    // Edge and W1C in the same cycle; eoi coincident with acknowledge.
    cfg_write(2'd1, 32'h4A);
    cfg_write(2'd0, 32'h0A);
    irq[6] = 1'b1;
    tick(2);
    cfg_we = 1'b1; cfg_addr = 2'd2; cfg_wdata = 32'h40;
    @(negedge clk);
    cfg_we = 1'b0; cfg_wdata = '0;
    rd(2'd2, 32'h40, "t6_set_wins");
    irq[6] = 1'b0;
    cfg_write(2'd2, 32'h40);
    rd(2'd2, 32'h00, "t6_w1c");
    pulse(3);
    tick(2);
    ack();
    rd(2'd3, 32'h08, "t6_insvc3");
    pulse(1);
    tick(2);
    lit_out("t6_req1", 1'b1, 4'd1, 23'h100);
    @(negedge clk); jisr = 1'b1;
    @(negedge clk); jisr = 1'b0; eoi = 1'b1;
    @(negedge clk); eoi = 1'b0;
    rd(2'd3, 32'h02, "t6_insvc_eoi");
    rd(2'd2, 32'h00, "t6_pending");

    tick(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/irq_arbiter.md
Name: irq_arbiter

Overview:
- Collects up to N_SRC external device interrupt lines and synchronises them.
- Latches edge or level requests, applies enable masks and nesting priority.
- Presents one winning request as an external-event cause bit on the cause vector feeding the interrupt controller.
- Tracks in-service sources via the jisr acknowledge and an end-of-interrupt pulse from the return path. Software configures it through a small register port.

Parameters:
- N_SRC, 8, number of external sources (1..16); index 0 = highest priority.
- CA_BASE, 7, bit position in the 23-bit cause vector for source 0; requires CA_BASE+N_SRC <= 23.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-low reset
- irq  in  N_SRC  asynchronous device request lines
- jisr  in  1  interrupt-taken pulse from interrupt controller
- eoi  in  1  end-of-interrupt pulse (one cycle, from return-from-exception)
- cfg_we  in  1  config write strobe
- cfg_addr  in  2  0=ENABLE, 1=EDGE, 2=PENDING, 3=INSVC
- cfg_wdata  in  32  write data, bits [N_SRC-1:0] used
- cfg_rdata  out  32  combinational read of cfg_addr, zero-extended
- ca_ext  out  23  cause contribution; only bit CA_BASE+irq_id may be 1
- irq_valid  out  1  request presented (state REQ)
- irq_id  out  4  index of presented/last-acknowledged source

Behaviour:
- Reset (rst=0 at a clk edge): sync flops, prev, ENABLE, EDGE, PENDING, INSVC = 0; state IDLE; ca_ext=0, irq_valid=0, irq_id=0. Applies from any state, including mid-REQ or ACK.
- Sync: two flops per line (s1, s2). Then prev <= s2.
- Edge source (EDGE[i]=1): PENDING[i] sets on s2 & ~prev. Stays set until cleared by ACK or a W1C write.
- Level source: PENDING[i] = registered s2. W1C has no lasting effect.
- Set beats clear when a new edge and a clear hit the same cycle.
- Latency: irq[i] high before edge k gives s1@k, s2@k+1, PENDING@k+2, REQ with ca_ext bit@k+3 (source eligible, state IDLE).
- Eligible[i] = PENDING[i] & ENABLE[i] & (i < lowest set index of INSVC, or INSVC==0). Winner = lowest eligible index.
- FSM IDLE:
  - any eligible: next state REQ, irq_id <= winner, ca_ext[CA_BASE+winner] <= 1.
  - jisr in IDLE is ignored (another cause).
- FSM REQ:
  - jisr=1: go ACK. ca_ext <= 0, irq_valid <= 0.
  - else re-arbitrate every cycle: a higher-priority arrival replaces irq_id and the ca_ext bit.
  - if nothing is eligible (level dropped, disabled): go IDLE, ca_ext <= 0.
- FSM ACK (one cycle):
  - INSVC[irq_id] <= 1.
  - If EDGE[irq_id], clear PENDING[irq_id].
  - Next IDLE. ACK->IDLE->REQ, so a re-request needs a minimum 2-cycle gap.
- eoi: clears the lowest set INSVC bit. Computed on pre-update INSVC when coincident with ACK (both apply). eoi with INSVC==0 is a no-op.
- Config writes:
  - ENABLE and EDGE: plain write.
  - PENDING: write-1-to-clear.
  - INSVC: write-1-to-clear (software recovery).
  - Writes take effect next cycle and are visible to arbitration from then.
- Changing EDGE of a pending source: the PENDING value is kept; the new mode governs future updates.
- Bits >= N_SRC read 0 and ignore writes.

Test Plan:
- Reset, ENABLE=0x01, EDGE=0x01, irq[0] 0->1 before edge 10 -> ca_ext[7]=1, irq_valid=1, irq_id=0 at edge 13. jisr at 15 -> ca_ext=0 at 15, INSVC=0x01 and PENDING=0 after ACK.
- ENABLE=0xFF, irq[5] pulsed (edge) then irq[2] pulsed 1 cycle later, no jisr -> irq_id moves 5->2, ca_ext bit 12 drops and bit 9 rises in the same cycle.
- INSVC=0x04 (source 2 in service), irq[3] pulses -> no request. eoi pulse -> INSVC=0, REQ for id 3 (ca_ext[10]=1) within 2 cycles.
- Level source 1 (EDGE=0) asserted then deasserted before jisr -> REQ then back to IDLE, ca_ext=0, INSVC unchanged.
- In REQ with id 4, assert rst=0 one cycle -> next cycle all outputs 0, all registers 0. Later irq edges produce nothing until ENABLE is rewritten.
- Edge on irq[6] arrives in the same cycle as W1C of PENDING bit 6 -> PENDING[6] stays 1. eoi coincident with ACK of id 1 while INSVC=0x08 -> INSVC=0x02.
